clk_div_mon: RTL and testbench

Receive-side monitor for the divided clock produced by the team's clock divider. It brings `clk_in` into the `clk` domain and emits one-cycle rise and fall strobes. It measures every half-period in `clk` cycles and runs a lock/fault state machine against the expected divide ratio. Downstream timed sequencers use its strobes and its `locked`/`fault` status in place of the raw divided clock.

---
 rtl/clk_div_mon_if.sv | 28 ++
 rtl/clk_div_mon.sv | 167 ++++++++++++++++
 tb/tb_clk_div_mon.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_mon_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_mon_if
// Purpose  : Enable and status bundle between clk_div_mon and its consumer.
// Revision : 1.0
// ============================================================================
interface clk_div_mon_if #(
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] half_period;
  logic             period_vld;
  logic             locked;
  logic             fault;

  modport master (
    input  en,
    output rise_pulse, fall_pulse, half_period, period_vld, locked, fault
  );

  modport slave (
    output en,
    input  rise_pulse, fall_pulse, half_period, period_vld, locked, fault
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_mon.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_mon
// Purpose  : Synchronises a divided clock, strobes its edges, measures each
//            half-period and tracks lock/fault against the expected ratio.
// Revision : 1.0
// ============================================================================
module clk_div_mon #(
  parameter int EXP_HALF = 1,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input wire            clk,
  input wire            rst_n,
  input wire            clk_in,
  clk_div_mon_if.master mon
);
  localparam int             c_gw       = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0] c_exp      = (CNT_W + 1)'(EXP_HALF);
  localparam logic [CNT_W:0] c_tol      = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W:0] c_hi       = (CNT_W + 1)'(EXP_HALF + TOL);
  localparam logic [c_gw-1:0] c_lock    = c_gw'(LOCK_CNT);
  localparam logic [c_gw-1:0] c_lock_m1 = c_gw'(LOCK_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_hp_cnt;
  logic             r_seen, w_seen_nxt;
  logic [c_gw-1:0]  r_good_cnt, w_good_nxt;
  logic             r_rise, r_fall, r_vld, r_locked, r_fault;
  logic [CNT_W-1:0] r_half;

  logic             w_edge, w_rise, w_fall, w_meas, w_good, w_timeout;
  logic [CNT_W:0]   w_hp_ext;

  // Flops reset high to match the divider's reset level: no false fall on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= clk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge    = r_s2 ^ r_s3;
  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_hp_ext  = {1'b0, r_hp_cnt};
  assign w_good    = ((w_hp_ext + c_tol) >= c_exp) && (w_hp_ext <= c_hi);
  assign w_timeout = ~w_edge & (w_hp_ext > c_hi);
  assign w_meas    = w_edge & mon.en & r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp_cnt <= '0;
    end else if (!mon.en || r_state == ST_IDLE) begin
      r_hp_cnt <= '0;
    end else if (w_edge) begin
      r_hp_cnt <= CNT_W'(1);
    end else if (!(&r_hp_cnt)) begin
      r_hp_cnt <= r_hp_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_seen     <= 1'b0;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_seen     <= w_seen_nxt;
      r_good_cnt <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seen_nxt  = r_seen;
    w_good_nxt  = r_good_cnt;
    case (r_state)
      ST_IDLE: begin
        w_seen_nxt = 1'b0;
        w_good_nxt = '0;
        if (mon.en) w_state_nxt = ST_ACQ;
      end
      ST_ACQ: begin
        if (w_edge) begin
          w_seen_nxt  = 1'b1;
          w_state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        // An edge always beats a timeout because w_timeout excludes edge cycles.
        if (w_meas) begin
          if (w_good) begin
            if (r_good_cnt >= c_lock_m1) begin
              w_good_nxt  = c_lock;
              w_state_nxt = ST_LOCKED;
            end else begin
              w_good_nxt = r_good_cnt + c_gw'(1);
            end
          end else begin
            w_good_nxt = '0;
          end
        end else if (w_timeout) begin
          w_good_nxt  = '0;
          w_seen_nxt  = 1'b0;
          w_state_nxt = ST_ACQ;
        end
      end
      ST_LOCKED: begin
        if ((w_meas && !w_good) || w_timeout) w_state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (!mon.en) begin
      w_state_nxt = ST_IDLE;
      w_seen_nxt  = 1'b0;
      w_good_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_vld    <= 1'b0;
      r_half   <= '0;
      r_locked <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_rise   <= mon.en & w_rise;
      r_fall   <= mon.en & w_fall;
      r_vld    <= w_meas;
      if (w_meas) r_half <= r_hp_cnt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_fault  <= (w_state_nxt == ST_FAULT);
    end
  end

  assign mon.rise_pulse  = r_rise;
  assign mon.fall_pulse  = r_fall;
  assign mon.period_vld  = r_vld;
  assign mon.half_period = r_half;
  assign mon.locked      = r_locked;
  assign mon.fault       = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_clk_div_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_mon
// Purpose  : Scoreboard bench for clk_div_mon at EXP_HALF=1 and EXP_HALF=3.
// Revision : 1.0
// ============================================================================
module tb_clk_div_mon;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clk_in_a;
  logic clk_in_bc;

  clk_div_mon_if #(.CNT_W(8)) if_a ();
  clk_div_mon_if #(.CNT_W(8)) if_b ();
  clk_div_mon_if #(.CNT_W(8)) if_c ();

  clk_div_mon #(.EXP_HALF(1), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in_a), .mon(if_a.master));
  clk_div_mon #(.EXP_HALF(3), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in_bc), .mon(if_b.master));
  clk_div_mon #(.EXP_HALF(3), .TOL(1), .LOCK_CNT(4), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in_bc), .mon(if_c.master));

  typedef struct packed {
    logic [7:0] hp;
    logic       lk;
    logic       ft;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rise_a_n = 0;
  int   fall_a_n = 0;
  int   strb_c_n = 0;
  logic a_exp_fall = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: period_vld with no expected entry", name);
  endtask

  function automatic exp_t mk(input int hp, input bit lk, input bit ft);
    exp_t r;
    r.hp = 8'(hp);
    r.lk = lk;
    r.ft = ft;
    return r;
  endfunction

  // Monitor: pops one expectation per period_vld, tracks strobe order/counts.
  always @(negedge clk) begin : mon_blk
    exp_t e;
    if (if_a.period_vld) begin
      if (q_a.size() == 0) fail_now("a_meas");
      else begin
        e = q_a.pop_front();
        chk("a_meas", {if_a.half_period, if_a.locked, if_a.fault}, e);
      end
    end
    if (if_b.period_vld) begin
      if (q_b.size() == 0) fail_now("b_meas");
      else begin
        e = q_b.pop_front();
        chk("b_meas", {if_b.half_period, if_b.locked, if_b.fault}, e);
      end
    end
    if (if_c.period_vld) begin
      if (q_c.size() == 0) fail_now("c_meas");
      else begin
        e = q_c.pop_front();
        chk("c_meas", {if_c.half_period, if_c.locked, if_c.fault}, e);
      end
    end
    if (!rst_n) begin
      a_exp_fall <= 1'b1;
    end else if (if_a.rise_pulse || if_a.fall_pulse) begin
      chk("a_strobe_order", {if_a.rise_pulse, if_a.fall_pulse}, a_exp_fall ? 2'b01 : 2'b10);
      a_exp_fall <= if_a.rise_pulse;
    end
    rise_a_n <= rise_a_n + int'(if_a.rise_pulse);
    fall_a_n <= fall_a_n + int'(if_a.fall_pulse);
    strb_c_n <= strb_c_n + int'(if_c.rise_pulse | if_c.fall_pulse);
  end

  task automatic step(input int gap, input exp_t eb, input exp_t ec);
    clk_in_bc = ~clk_in_bc;
    q_b.push_back(eb);
    q_c.push_back(ec);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int rb, fb, cb;
    rst_n     = 1'b0;
    clk_in_a  = 1'b1;
    clk_in_bc = 1'b1;
    if_a.en   = 1'b1;
    if_b.en   = 1'b1;
    if_c.en   = 1'b1;

    // Reset release with clk_in high
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("a_rst_outs", {if_a.rise_pulse, if_a.fall_pulse, if_a.period_vld, if_a.locked, if_a.fault, if_a.half_period}, 0);
    chk("b_rst_outs", {if_b.rise_pulse, if_b.fall_pulse, if_b.period_vld, if_b.locked, if_b.fault, if_b.half_period}, 0);
    chk("c_rst_outs", {if_c.rise_pulse, if_c.fall_pulse, if_c.period_vld, if_c.locked, if_c.fault, if_c.half_period}, 0);
    chk("a_no_fall_at_rst", fall_a_n, 0);

    // EXP_HALF=1: toggle every cycle, then reset mid-lock
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      clk_in_a = ~clk_in_a;
      if (k >= 2) q_a.push_back(mk(1, k >= 5, 1'b0));
    end
    #1 chk("a_locked_before_rst", if_a.locked, 1);
    #1 rst_n = 1'b0;
    #1 chk("a_async_rst_outs", {if_a.rise_pulse, if_a.fall_pulse, if_a.period_vld, if_a.locked, if_a.fault, if_a.half_period}, 0);
    q_a.delete();
    clk_in_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full re-acquisition after reset, then stop toggling
    repeat (3) @(negedge clk);
    rb = rise_a_n;
    fb = fall_a_n;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      clk_in_a = ~clk_in_a;
      if (k >= 2) q_a.push_back(mk(1, k >= 5, 1'b0));
    end
    repeat (6) @(negedge clk);
    chk("a_stuck_fault", {if_a.locked, if_a.fault}, 2'b01);
    chk("a_queue_drained", q_a.size(), 0);
    chk("a_rise_count", rise_a_n - rb, 4);
    chk("a_fall_count", fall_a_n - fb, 4);
    if_a.en = 1'b0;
    @(negedge clk);
    chk("a_en_clear", {if_a.locked, if_a.fault}, 0);

    // EXP_HALF=3: latency of first strobe
    @(negedge clk);
    clk_in_bc = ~clk_in_bc;
    repeat (2) @(negedge clk);
    chk("b_strobe_early", if_b.fall_pulse, 0);
    @(negedge clk);
    chk("b_strobe_latency", if_b.fall_pulse, 1);

    // Lock, stretched half-period (bad for TOL=0, good for TOL=1), freeze
    step(3, mk(3, 0, 0), mk(3, 0, 0));
    step(3, mk(3, 0, 0), mk(3, 0, 0));
    step(3, mk(3, 0, 0), mk(3, 0, 0));
    step(3, mk(3, 1, 0), mk(3, 1, 0));
    step(3, mk(3, 1, 0), mk(3, 1, 0));
    step(4, mk(3, 1, 0), mk(3, 1, 0));
    step(3, mk(4, 0, 1), mk(4, 1, 0));
    step(3, mk(3, 0, 1), mk(3, 1, 0));
    step(3, mk(3, 0, 1), mk(3, 1, 0));
    step(0, mk(3, 0, 1), mk(3, 1, 0));
    repeat (4) @(negedge clk);
    cb = strb_c_n;
    repeat (3) @(negedge clk);
    chk("c_before_timeout", {if_c.locked, if_c.fault}, 2'b10);
    @(negedge clk);
    chk("c_timeout_fault", {if_c.locked, if_c.fault}, 2'b01);
    repeat (8) @(negedge clk);
    chk("c_no_strobes_frozen", strb_c_n - cb, 0);
    chk("b_fault_sticky", {if_b.locked, if_b.fault}, 2'b01);
    chk("b_queue_drained", q_b.size(), 0);
    chk("c_queue_drained", q_c.size(), 0);

    // Recovery through en
    if_b.en = 1'b0;
    if_c.en = 1'b0;
    @(negedge clk);
    chk("b_en_clear", {if_b.locked, if_b.fault}, 0);
    chk("c_en_clear", {if_c.locked, if_c.fault}, 0);
    repeat (2) @(negedge clk);
    if_b.en = 1'b1;
    if_c.en = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    clk_in_bc = ~clk_in_bc;
    repeat (3) @(negedge clk);
    step(3, mk(3, 0, 0), mk(3, 0, 0));
    step(3, mk(3, 0, 0), mk(3, 0, 0));
    step(3, mk(3, 0, 0), mk(3, 0, 0));
    step(0, mk(3, 1, 0), mk(3, 1, 0));
    repeat (4) @(negedge clk);
    chk("b_relock", {if_b.locked, if_b.fault}, 2'b10);
    chk("c_relock", {if_c.locked, if_c.fault}, 2'b10);
    chk("b_queue_drained_2", q_b.size(), 0);
    chk("c_queue_drained_2", q_c.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
